// File: rtl/reg_access_ctrl_pkg.sv
// Shared widths, instruction field layout and sequencer state encoding
// for the register-access sequencer in front of reg_bank.
package reg_access_ctrl_pkg;

  localparam int BITS     = 8;
  localparam int REG_BITS = 2;
  localparam int REG_SIZE = 4;

  // instruction word: [7:4] opcode, [3:2] ra (src A / dest), [1:0] rb (src B)
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RA_MSB  = 3;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;

  // opcode bit that suppresses writeback when set
  localparam int WB_BIT = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    WRITE    = 3'd4
  } state_t;

endpackage

// File: rtl/reg_access_ctrl_instr_decode.sv
// Combinational field extraction for one instruction word.
module instr_decode
  import reg_access_ctrl_pkg::*;
#(
  parameter int BITS     = reg_access_ctrl_pkg::BITS,
  parameter int REG_BITS = reg_access_ctrl_pkg::REG_BITS
) (
  input  logic [BITS-1:0]     instr,
  output logic [3:0]          opcode,
  output logic [REG_BITS-1:0] ra,
  output logic [REG_BITS-1:0] rb,
  output logic                wb
);

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign ra     = instr[RA_MSB:RA_LSB];
  assign rb     = instr[RB_MSB:RB_LSB];
  // opcodes 0x0-0x7 write back, 0x8-0xF are compare/store style (no write)
  assign wb     = ~instr[OPC_LSB+WB_BIT];

endmodule

// File: rtl/reg_access_ctrl.sv
// One-instruction-at-a-time sequencer: fetch operands from reg_bank,
// hand them to the ALU, and write the ALU result back to ra.
module reg_access_ctrl
  import reg_access_ctrl_pkg::*;
#(
  parameter int BITS     = reg_access_ctrl_pkg::BITS,
  parameter int REG_BITS = reg_access_ctrl_pkg::REG_BITS,
  parameter int REG_SIZE = reg_access_ctrl_pkg::REG_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [BITS-1:0]     instr,
  output logic                instr_ready,
  output logic [REG_BITS-1:0] address_a,
  output logic [REG_BITS-1:0] address_b,
  input  logic [BITS-1:0]     data_a,
  input  logic [BITS-1:0]     data_b,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [3:0]          opcode,
  output logic [BITS-1:0]     operand_a,
  output logic [BITS-1:0]     operand_b,
  input  logic                result_valid,
  input  logic [BITS-1:0]     result,
  output logic                write_enable,
  output logic [REG_BITS-1:0] write_address,
  output logic [BITS-1:0]     write_data,
  output logic                busy
);

  if (REG_SIZE != (1 << REG_BITS)) begin : g_bad_cfg
    $error("REG_SIZE must equal 2**REG_BITS");
  end

  state_t              state_q, state_d;
  logic [BITS-1:0]     instr_q;
  logic [REG_BITS-1:0] ra, rb;
  logic                wb;
  logic                accept, capture_ops, capture_res;

  instr_decode #(
    .BITS     (BITS),
    .REG_BITS (REG_BITS)
  ) u_decode (
    .instr  (instr_q),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .wb     (wb)
  );

  // instr_q only changes on accept, so the read addresses are stable
  // everywhere outside the FETCH that follows it
  assign address_a   = ra;
  assign address_b   = rb;
  assign instr_ready = (state_q == IDLE) && !rst;
  assign op_valid    = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);

  assign accept      = (state_q == IDLE) && instr_valid;
  assign capture_ops = (state_q == FETCH);
  assign capture_res = (state_q == WAIT_RES) && result_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (instr_valid) state_d = FETCH;
      FETCH:    state_d = ISSUE;
      ISSUE:    if (op_ready) state_d = wb ? WAIT_RES : IDLE;
      WAIT_RES: if (result_valid) state_d = WRITE;
      WRITE:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // reset takes priority over a same-cycle result, so a cancelled
  // instruction never reaches the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      state_q      <= state_d;
      write_enable <= capture_res;
      if (accept) instr_q <= instr;
      if (capture_ops) begin
        operand_a <= data_a;
        operand_b <= data_b;
      end
      if (capture_res) begin
        write_address <= ra;
        write_data    <= result;
      end
    end
  end

endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
- Multi-cycle sequencer sitting directly upstream of reg_bank.
- Accepts one instruction word at a time and decodes its register fields.
- Drives reg_bank read addresses, captures both operands and hands them to the ALU via a valid/ready handshake.
- Waits for the ALU result and drives reg_bank's write port for exactly one cycle.
- Only one instruction is in flight at a time, so no forwarding logic is needed.

Parameters:
- BITS, 8, data and instruction width.
- REG_BITS, 2, register address width.
- REG_SIZE, 4, number of registers (2**REG_BITS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction word is offered.
- instr  input  BITS  instruction word: [7:4] opcode, [3:2] ra (source A and destination), [1:0] rb (source B).
- instr_ready  output  1  block can accept an instruction.
- address_a  output  REG_BITS  reg_bank read address A.
- address_b  output  REG_BITS  reg_bank read address B.
- data_a  input  BITS  reg_bank read data A; combinational from address_a.
- data_b  input  BITS  reg_bank read data B; combinational from address_b.
- op_valid  output  1  operands presented to the ALU.
- op_ready  input  1  ALU accepts the operands.
- opcode  output  4  latched opcode.
- operand_a  output  BITS  latched data_a.
- operand_b  output  BITS  latched data_b.
- result_valid  input  1  ALU result available.
- result  input  BITS  ALU result.
- write_enable  output  1  reg_bank write strobe.
- write_address  output  REG_BITS  reg_bank write address.
- write_data  output  BITS  reg_bank write data.
- busy  output  1  instruction in flight (state != IDLE).

Behaviour:
- Reset (rst high at a rising edge):
  - State goes to IDLE.
  - All registered outputs go to 0: the latched instruction, operand_a, operand_b, write_enable, write_address and write_data.
  - instr_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
  - Reset mid-operation drops the instruction in flight and never writes it back.
- Writeback flag: wb = !opcode[3]. Opcodes 0x0-0x7 write result to ra; opcodes 0x8-0xF do not write back.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch instr and go to FETCH.
- FETCH (1 cycle):
  - address_a=ra, address_b=rb.
  - data_a and data_b are latched into operand_a and operand_b at the end of the cycle.
  - Next state is ISSUE.
- ISSUE:
  - op_valid=1; opcode and operands are held stable until op_ready.
  - On op_ready: go to WAIT_RES if wb, otherwise to IDLE.
- WAIT_RES:
  - On result_valid, latch result into write_data, set write_address=ra and go to WRITE.
- WRITE (1 cycle):
  - write_enable=1; reg_bank commits at the end of this cycle.
  - Next state is IDLE.
- Outside WRITE, write_enable=0.
- Outside FETCH, address_a and address_b hold their last values (no glitching required).
- result_valid outside WAIT_RES is ignored. op_ready outside ISSUE is ignored.
- Latency, with op_ready and result_valid held high:
  - Accept at edge 0; FETCH in cycle 1; op_valid in cycle 2.
  - WAIT_RES in cycle 3; write_enable in cycle 4; instr_ready again in cycle 5.
  - Non-wb instruction: instr_ready again in cycle 3.
- Read-after-write: the next FETCH always follows the previous WRITE cycle, so a dependent instruction reads the new value. No forwarding is required.
- ra == rb is legal: both operands equal reg[ra].
- Widths: no arithmetic in this block; all fields are straight bit slices.

Decomposition:
- utils.vh carries:
  - BITS, REG_BITS and REG_SIZE defines;
  - instruction field positions (OPC_MSB/LSB, RA_MSB/LSB, RB_MSB/LSB);
  - the WB flag bit position;
  - the 3-bit state encodings IDLE=0, FETCH=1, ISSUE=2, WAIT_RES=3, WRITE=4.
- One natural sub-module: instr_decode, purely combinational. It takes instr and produces opcode, ra, rb and wb.

Test Plan:
Bench wraps a behavioural reg_bank model preloaded with reg = {0x11, 0x22, 0x33, 0x44}.
1. rst held 2 cycles with instr_valid=1 -> instr_ready=0, write_enable=0, op_valid=0 throughout. After release: instr_ready=1, busy=0.
2. instr=0x1B (op 1, ra=2, rb=3), op_ready=1, ALU returns 0x77 the cycle after op handshake -> cycle 2: op_valid=1, opcode=1, operand_a=0x33, operand_b=0x44. Cycle 4: write_enable=1, write_address=2, write_data=0x77. Cycle 5: instr_ready=1.
3. instr=0x9B (no writeback) -> one op handshake with operand_a=0x33, operand_b=0x44. write_enable stays 0. instr_ready=1 in cycle 3.
4. op_ready held low 5 cycles, then high -> op_valid, opcode and operands stay stable during the stall. Exactly one handshake occurs. A stray result_valid pulse during the stall causes no write.
5. Back-to-back 0x1B (result 0x77), then 0x18 (ra=2, rb=0) -> second FETCH reads operand_a=0x77 (new value) and operand_b=0x11.
6. rst asserted during WAIT_RES with result_valid=1 in the same cycle -> no write_enable pulse. reg[2] keeps its old value. State returns to IDLE.
